// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state encoding and the operand magnitude helper.
package mdu_pkg;

    // Widest operand the magnitude helper supports
    localparam int unsigned MDU_XLEN_MAX = 64;

    // funct3 encodings of the M-extension ops
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } mdu_state_e;

    // Magnitude of a width-bit value held zero-extended in a wide container;
    // the value is negated only when it is signed and its sign bit is set.
    function automatic logic [MDU_XLEN_MAX-1:0] abs_sel(
        input logic [MDU_XLEN_MAX-1:0] value,
        input int unsigned             width,
        input logic                    is_signed
    );
        logic [MDU_XLEN_MAX-1:0] mask;
        logic [MDU_XLEN_MAX-1:0] top;
        logic                    neg;
        mask = (width >= MDU_XLEN_MAX) ? '1
             : ((MDU_XLEN_MAX'(1) << width) - MDU_XLEN_MAX'(1));
        top  = value >> (width - 1);
        neg  = is_signed & top[0];
        return neg ? ((~value + MDU_XLEN_MAX'(1)) & mask) : (value & mask);
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-divide step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module mdu_divstep #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] divisor,
    input  logic         din,
    output logic [W-1:0] rem_next_c,
    output logic         q_bit_c
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // Trial subtraction; the remainder is always below the divisor, so the
    // difference fits in W+1 bits and its top bit is a clean borrow flag.
    always_comb begin
        shifted    = {rem, din};
        diff       = shifted - {1'b0, divisor};
        q_bit_c    = ~diff[W];
        rem_next_c = q_bit_c ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide over XLEN cycles, with a
// one-edge fast path for divide-by-zero and signed overflow.
// Build option: MDU_EARLY_OUT_EN lets multiplies finish as soon as the
// remaining multiplier bits are all zero.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      OP,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      RD_IN,
    input  logic            KILL,
    output logic            BUSY,
    output logic            STALL,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      RD_OUT
);

    localparam int unsigned       PW      = 2 * XLEN;
    localparam logic [XLEN-1:0]   MIN_NEG = XLEN'(1) << (XLEN - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [2:0]       op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [4:0]       rd_q, rd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [4:0]       rd_out_q, rd_out_d;

    logic             signed_a, signed_b;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic             div_zero, div_ovf;
    logic [XLEN-1:0]  fast_res;
    logic [XLEN:0]    mul_sum;
    logic [PW-1:0]    mul_shift;
    logic [XLEN-1:0]  div_rem;
    logic             div_q;
    logic [PW-1:0]    prod, prod_s;
    logic [XLEN-1:0]  quo_s, rem_s;
    logic [XLEN-1:0]  fix_res;

    // Operand decode at request time: signedness, magnitudes, fast-path cases
    always_comb begin
        signed_a = (OP == MDU_MULH) || (OP == MDU_MULHSU) || (OP == MDU_DIV) || (OP == MDU_REM);
        signed_b = (OP == MDU_MULH) || (OP == MDU_DIV) || (OP == MDU_REM);
        abs_a    = XLEN'(abs_sel(MDU_XLEN_MAX'(A), XLEN, signed_a));
        abs_b    = XLEN'(abs_sel(MDU_XLEN_MAX'(B), XLEN, signed_b));
        div_zero = (B == '0);
        div_ovf  = ((OP == MDU_DIV) || (OP == MDU_REM)) && (A == MIN_NEG) && (B == '1);
        if (div_zero) begin
            fast_res = OP[1] ? A : '1;
        end else begin
            fast_res = OP[1] ? '0 : A;
        end
    end

    // Multiply step: add multiplicand on the multiplier LSB, then shift right
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_shift = {mul_sum, acc_lo_q[XLEN-1:1]};
    end

    mdu_divstep #(
        .W (XLEN)
    ) u_divstep (
        .rem        (acc_hi_q),
        .divisor    (opnd_q),
        .din        (acc_lo_q[XLEN-1]),
        .rem_next_c (div_rem),
        .q_bit_c    (div_q)
    );

`ifdef MDU_EARLY_OUT_EN
    logic [PW-1:0] rem_mask;
    logic          early_hit;
    logic [PW-1:0] early_prod;

    // Skip the tail of a multiply once the unprocessed multiplier bits are zero
    always_comb begin
        rem_mask   = (PW'(1) << (cnt_q - CNT_W'(1))) - PW'(1);
        early_hit  = ~op_q[2] && (cnt_q != CNT_W'(1)) && ((mul_shift & rem_mask) == '0);
        early_prod = mul_shift >> (cnt_q - CNT_W'(1));
    end
`endif

    // Sign correction and result selection for the final cycle
    always_comb begin
        prod   = {acc_hi_q, acc_lo_q};
        prod_s = (sa_q ^ sb_q) ? (~prod + PW'(1)) : prod;
        quo_s  = (sa_q ^ sb_q) ? (~acc_lo_q + XLEN'(1)) : acc_lo_q;
        rem_s  = sa_q ? (~acc_hi_q + XLEN'(1)) : acc_hi_q;
        case (op_q)
            MDU_MUL:                        fix_res = prod_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_s[PW-1:XLEN];
            MDU_DIV, MDU_DIVU:              fix_res = quo_s;
            default:                        fix_res = rem_s;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        case (state_q)
            S_IDLE: begin
                if (START && !KILL) begin
                    op_d = OP;
                    rd_d = RD_IN;
                    sa_d = signed_a & A[XLEN-1];
                    sb_d = signed_b & B[XLEN-1];
                    if (OP[2] && (div_zero || div_ovf)) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                        rd_out_d = RD_IN;
                    end else begin
                        state_d  = S_CALC;
                        cnt_d    = CNT_W'(XLEN);
                        acc_hi_d = '0;
                        acc_lo_d = OP[2] ? abs_a : abs_b;
                        opnd_d   = OP[2] ? abs_b : abs_a;
                    end
                end
            end
            S_CALC: begin
                if (KILL) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q[2]) begin
                        acc_hi_d = div_rem;
                        acc_lo_d = {acc_lo_q[XLEN-2:0], div_q};
                    end else begin
                        {acc_hi_d, acc_lo_d} = mul_shift;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIXUP;
                    end
`ifdef MDU_EARLY_OUT_EN
                    if (early_hit) begin
                        {acc_hi_d, acc_lo_d} = early_prod;
                        state_d              = S_FIXUP;
                    end
`endif
                end
            end
            S_FIXUP: begin
                if (KILL) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIXUP);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            rd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign RD_OUT = rd_out_q;
    assign STALL  = busy_q | (START & (state_q == S_IDLE));

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative (XLEN=32).
module tb_mdu_iterative;
    import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [2:0]  OP;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  RD_IN;
    logic        KILL;
    logic        BUSY;
    logic        STALL;
    logic        DONE;
    logic [31:0] RESULT;
    logic [4:0]  RD_OUT;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    mdu_iterative #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .OP     (OP),
        .A      (A),
        .B      (B),
        .RD_IN  (RD_IN),
        .KILL   (KILL),
        .BUSY   (BUSY),
        .STALL  (STALL),
        .DONE   (DONE),
        .RESULT (RESULT),
        .RD_OUT (RD_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Expected multiply latency for a multiplier magnitude
    function automatic int lat_mul(input logic [31:0] bmag);
        int k;
        k = 0;
        for (int i = 0; i < 32; i++) if (bmag[i]) k = i;
        return (EARLY_EN && (k + 3 < 34)) ? k + 3 : 34;
    endfunction

    // Issue one op, measure latency/stall, check result, tag and pulse width
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat, input bit poke);
        int edges;
        int stall_cnt;
        bit seen;
        @(negedge CLK);
        OP = op; A = a; B = b; RD_IN = rd; START = 1'b1;
        #1;
        stall_cnt = STALL ? 1 : 0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 100) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
            edges++;
            if (DONE) seen = 1'b1;
            else begin
                if (STALL) stall_cnt++;
                if (poke && edges == 5) begin
                    START = 1'b1; OP = MDU_MUL; A = 32'd0; B = 32'd0;
                end
            end
        end
        check({tag, " latency"}, 32'(edges), 32'(exp_lat));
        check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check({tag, " result"}, RESULT, exp_res);
        check({tag, " rd_out"}, 32'(RD_OUT), 32'(rd));
        check({tag, " stall_at_done"}, 32'(STALL), 32'd0);
        @(posedge CLK);
        #1;
        check({tag, " done_pulse_width"}, 32'(DONE), 32'd0);
        last_res = exp_res;
        last_rd  = rd;
    endtask

    initial begin
        int done_cnt;
        RESET = 1'b0; START = 1'b0; KILL = 1'b0;
        OP = 3'd0; A = 32'd0; B = 32'd0; RD_IN = 5'd0;
        #12;
        check("reset busy",   32'(BUSY),   32'd0);
        check("reset done",   32'(DONE),   32'd0);
        check("reset result", RESULT,      32'd0);
        check("reset rd_out", 32'(RD_OUT), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        run_op("mul_7x-3",      MDU_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34, 1'b0);
        run_op("mulhu_ff",      MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34, 1'b0);
        run_op("mulh_ff",       MDU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, lat_mul(32'd1), 1'b0);
        run_op("mulhsu_-1x2",   MDU_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, lat_mul(32'd2), 1'b0);
        run_op("div_-7/2",      MDU_DIV,    32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 34, 1'b1);
        run_op("rem_-7/2",      MDU_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 34, 1'b0);
        run_op("divu_100/7",    MDU_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       34, 1'b0);
        run_op("remu_100/7",    MDU_REMU,   32'd100,      32'd7,        5'd8,  32'd2,        34, 1'b0);
        run_op("divu_13/0",     MDU_DIVU,   32'd13,       32'd0,        5'd9,  32'hFFFFFFFF, 1,  1'b0);
        run_op("remu_13/0",     MDU_REMU,   32'd13,       32'd0,        5'd10, 32'd13,       1,  1'b0);
        run_op("div_ovf",       MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1,  1'b0);
        run_op("rem_ovf",       MDU_REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1,  1'b0);
        run_op("rem_-5/0",      MDU_REM,    32'hFFFFFFFB, 32'd0,        5'd14, 32'hFFFFFFFB, 1,  1'b0);

        // Kill a divide ten cycles in: no DONE, previous result and tag kept
        @(negedge CLK);
        OP = MDU_DIV; A = 32'd1000; B = 32'd3; RD_IN = 5'd20; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        KILL = 1'b1;
        @(posedge CLK);
        #1;
        KILL = 1'b0;
        check("kill busy_low", 32'(BUSY), 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (DONE) done_cnt++;
        end
        check("kill no_done",     32'(done_cnt), 32'd0);
        check("kill result_kept", RESULT,        last_res);
        check("kill rd_kept",     32'(RD_OUT),   32'(last_rd));
        run_op("mul_3x4", MDU_MUL, 32'd3, 32'd4, 5'd13, 32'd12, lat_mul(32'd4), 1'b0);

        // Asynchronous reset in the middle of a calculation
        @(negedge CLK);
        OP = MDU_DIVU; A = 32'd100; B = 32'd7; RD_IN = 5'd3; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("async_rst busy",   32'(BUSY),   32'd0);
        check("async_rst done",   32'(DONE),   32'd0);
        check("async_rst stall",  32'(STALL),  32'd0);
        check("async_rst result", RESULT,      32'd0);
        check("async_rst rd_out", 32'(RD_OUT), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        run_op("rem_9/4", MDU_REM, 32'd9, 32'd4, 5'd17, 32'd1, 34, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
